// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - N_CH-channel PWM sharing one period counter, double-buffered config; optional macro PWM_DEADTIME_EN
module pwm_multi #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 8,
  parameter int DT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   cfg_load,
  input  logic [WIDTH-1:0]       cfg_period,
  input  logic [N_CH*WIDTH-1:0]  cfg_duty,
  input  logic                   cfg_center,
`ifdef PWM_DEADTIME_EN
  input  logic [DT_WIDTH-1:0]    cfg_deadtime,
  output logic [N_CH-1:0]        pwm_n_out,
`endif
  output logic [N_CH-1:0]        pwm_out,
  output logic                   period_start,
  output logic                   update_pending
);

  if (N_CH < 1 || N_CH > 8 || WIDTH < 1 || DT_WIDTH < 1) begin : g_bad_param
    $error("pwm_multi: parameter out of range");
  end

  logic                   run_q, run_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic                   dir_q, dir_d;
  logic [WIDTH-1:0]       sh_period_q, sh_period_d, act_period_q, act_period_d;
  logic [N_CH*WIDTH-1:0]  sh_duty_q, sh_duty_d, act_duty_q, act_duty_d;
  logic                   sh_center_q, sh_center_d, act_center_q, act_center_d;
  logic                   pend_q, pend_d;
  logic [N_CH-1:0]        pwm_q, pwm_d;
  logic                   ps_q, ps_d;

  logic                   running;
  logic                   last;
  logic                   commit;
  logic [WIDTH-1:0]       pe_m1;
  logic [N_CH-1:0]        cmp;

`ifdef PWM_DEADTIME_EN
  logic [DT_WIDTH-1:0]             sh_dt_q, sh_dt_d, act_dt_q, act_dt_d;
  logic [N_CH-1:0][DT_WIDTH-1:0]   dt_cnt_q, dt_cnt_d;
  logic [N_CH-1:0][DT_WIDTH-1:0]   rem;
  logic [N_CH-1:0]                 prev_p_q, prev_p_d, prev_n_q, prev_n_d;
  logic [N_CH-1:0]                 pwm_n_q, pwm_n_d;
  logic [N_CH-1:0]                 raw_p, raw_n;
`endif

  // Period counter: edge mode wraps at Pa, center mode bounces with each endpoint held twice
  always_comb begin
    run_d   = enable;
    running = enable & run_q;
    pe_m1   = (act_period_q == '0) ? '0 : act_period_q - 1'b1;
    last    = act_center_q ? (dir_q && (cnt_q == '0)) : (cnt_q == act_period_q);
    commit  = (running & last) | ~enable;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (!running || last) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (!act_center_q) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!dir_q) begin
      if (cnt_q == pe_m1) dir_d = 1'b1;
      else                cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Shadow capture and commit; a load landing on a commit point goes straight to the active set
  always_comb begin
    sh_period_d  = sh_period_q;
    sh_duty_d    = sh_duty_q;
    sh_center_d  = sh_center_q;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    act_center_d = act_center_q;
    pend_d       = pend_q;
`ifdef PWM_DEADTIME_EN
    sh_dt_d      = sh_dt_q;
    act_dt_d     = act_dt_q;
`endif
    if (cfg_load) begin
      sh_period_d = cfg_period;
      sh_duty_d   = cfg_duty;
      sh_center_d = cfg_center;
`ifdef PWM_DEADTIME_EN
      sh_dt_d     = cfg_deadtime;
`endif
    end
    if (commit) begin
      if (cfg_load || pend_q) begin
        act_period_d = sh_period_d;
        act_duty_d   = sh_duty_d;
        act_center_d = sh_center_d;
`ifdef PWM_DEADTIME_EN
        act_dt_d     = sh_dt_d;
`endif
      end
      pend_d = 1'b0;
    end else if (cfg_load) begin
      pend_d = 1'b1;
    end
  end

  // Per-channel duty compare, optional dead-time insertion, period-start flag
  always_comb begin
    cmp   = '0;
    pwm_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      cmp[i] = (cnt_q < act_duty_q[i*WIDTH +: WIDTH]);
    end
    ps_d = running & (cnt_q == '0) & ~dir_q;
`ifdef PWM_DEADTIME_EN
    raw_p    = '0;
    raw_n    = '0;
    rem      = '0;
    pwm_n_d  = '0;
    dt_cnt_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      raw_p[i]    = running & cmp[i];
      raw_n[i]    = running & ~cmp[i];
      rem[i]      = ((raw_p[i] != prev_p_q[i]) || (raw_n[i] != prev_n_q[i])) ? act_dt_q : dt_cnt_q[i];
      pwm_d[i]    = raw_p[i] & (rem[i] == '0);
      pwm_n_d[i]  = raw_n[i] & (rem[i] == '0);
      dt_cnt_d[i] = (rem[i] == '0) ? '0 : rem[i] - 1'b1;
    end
    prev_p_d = raw_p;
    prev_n_d = raw_n;
`else
    pwm_d = {N_CH{running}} & cmp;
`endif
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q        <= 1'b0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      sh_period_q  <= '0;
      sh_duty_q    <= '0;
      sh_center_q  <= 1'b0;
      act_period_q <= '0;
      act_duty_q   <= '0;
      act_center_q <= 1'b0;
      pend_q       <= 1'b0;
      pwm_q        <= '0;
      ps_q         <= 1'b0;
`ifdef PWM_DEADTIME_EN
      sh_dt_q      <= '0;
      act_dt_q     <= '0;
      dt_cnt_q     <= '0;
      prev_p_q     <= '0;
      prev_n_q     <= '0;
      pwm_n_q      <= '0;
`endif
    end else begin
      run_q        <= run_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      sh_period_q  <= sh_period_d;
      sh_duty_q    <= sh_duty_d;
      sh_center_q  <= sh_center_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      act_center_q <= act_center_d;
      pend_q       <= pend_d;
      pwm_q        <= pwm_d;
      ps_q         <= ps_d;
`ifdef PWM_DEADTIME_EN
      sh_dt_q      <= sh_dt_d;
      act_dt_q     <= act_dt_d;
      dt_cnt_q     <= dt_cnt_d;
      prev_p_q     <= prev_p_d;
      prev_n_q     <= prev_n_d;
      pwm_n_q      <= pwm_n_d;
`endif
    end
  end

  assign pwm_out        = pwm_q;
  assign period_start   = ps_q;
  assign update_pending = pend_q;
`ifdef PWM_DEADTIME_EN
  assign pwm_n_out      = pwm_n_q;
`endif

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - scoreboard bench for pwm_multi (dead-time checks only when PWM_DEADTIME_EN is defined)
module tb_pwm_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        cfg_load;
  logic [7:0]  cfg_period;
  logic [31:0] cfg_duty;
  logic        cfg_center;
  logic [3:0]  cfg_deadtime;
  logic [3:0]  pwm_out;
  logic        period_start;
  logic        update_pending;
`ifdef PWM_DEADTIME_EN
  logic [3:0]  pwm_n_out;
`else
  wire  [3:0]  pwm_n_out = 4'h0;
`endif

  always #5 clk = ~clk;

  pwm_multi #(.N_CH(4), .WIDTH(8), .DT_WIDTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .cfg_load       (cfg_load),
    .cfg_period     (cfg_period),
    .cfg_duty       (cfg_duty),
    .cfg_center     (cfg_center),
`ifdef PWM_DEADTIME_EN
    .cfg_deadtime   (cfg_deadtime),
    .pwm_n_out      (pwm_n_out),
`endif
    .pwm_out        (pwm_out),
    .period_start   (period_start),
    .update_pending (update_pending)
  );

  // expected vector layout: {pwm_n[3:0], update_pending, period_start, pwm[3:0]}
  typedef struct {
    string      nm;
    logic [9:0] ex;
    logic [9:0] mk;
  } exp_t;

  localparam logic [9:0] M_MAIN = 10'h03F;
  localparam logic [9:0] M_DT   = 10'h3FF;

  exp_t       sb_q[$];
  exp_t       cur;
  logic [9:0] act_v;
  int         n_checks = 0;
  int         n_pass   = 0;

  function automatic logic [9:0] ev(input logic [3:0] pw, input logic ps, input logic up,
                                    input logic [3:0] pn);
    return {pn, up, ps, pw};
  endfunction

  function automatic logic [3:0] pat(input int c, input int d0, input int d1, input int d2, input int d3);
    return {c < d3, c < d2, c < d1, c < d0};
  endfunction

  task automatic cyc(input string nm, input logic [9:0] ex, input logic [9:0] mk);
    @(posedge clk);
    sb_q.push_back('{nm, ex, mk});
    #1;
  endtask

  task automatic set_cfg(input int p, input int d0, input int d1, input int d2, input int d3,
                         input logic c, input int dt);
    cfg_period   = p[7:0];
    cfg_duty     = {d3[7:0], d2[7:0], d1[7:0], d0[7:0]};
    cfg_center   = c;
    cfg_deadtime = dt[3:0];
  endtask

  // Monitor: one scoreboard entry per cycle it was pushed, compared mid-cycle
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur   = sb_q.pop_front();
      act_v = {pwm_n_out, update_pending, period_start, pwm_out};
      n_checks++;
      if ((act_v & cur.mk) === (cur.ex & cur.mk)) n_pass++;
      else $display("FAIL %s: actual %h required %h (mask %h) at %0t", cur.nm, act_v, cur.ex, cur.mk, $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph;
    logic [3:0] pw;
    logic up;
    reset = 1'b1; enable = 1'b0; cfg_load = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 1'b0, 0);
    @(posedge clk); #1;
    cyc("reset", ev(4'h0, 0, 0, 4'h0), M_MAIN);
    reset = 1'b0;

    // Edge mode P=9, duty {0,3,9,10}
    set_cfg(9, 0, 3, 9, 10, 1'b0, 0); cfg_load = 1'b1;
    cyc("t1_load_idle", ev(4'h0, 0, 0, 4'h0), M_MAIN);
    cfg_load = 1'b0; enable = 1'b1;
    cyc("t1_first", ev(4'h0, 0, 0, 4'h0), M_MAIN);
    for (int k = 0; k < 30; k++) begin
      ph = k % 10;
      cyc("t1_edge", ev(pat(ph, 0, 3, 9, 10), ph == 0, 0, 4'h0), M_MAIN);
    end

    // Center mode P=8, duty {0,3,8,9}
    enable = 1'b0; set_cfg(8, 0, 3, 8, 9, 1'b1, 0); cfg_load = 1'b1;
    cyc("t2_dis", ev(4'h0, 0, 0, 4'h0), M_MAIN);
    cfg_load = 1'b0; enable = 1'b1;
    cyc("t2_first", ev(4'h0, 0, 0, 4'h0), M_MAIN);
    for (int k = 0; k < 32; k++) begin
      ph = k % 16;
      cyc("t2_center", ev(pat((ph < 8) ? ph : 15 - ph, 0, 3, 8, 9), ph == 0, 0, 4'h0), M_MAIN);
    end

    // Mid-period reload, wrap-cycle bypass, last-write-wins
    enable = 1'b0; set_cfg(9, 5, 5, 5, 5, 1'b0, 0); cfg_load = 1'b1;
    cyc("t3_dis", ev(4'h0, 0, 0, 4'h0), M_MAIN);
    cfg_load = 1'b0; enable = 1'b1;
    cyc("t3_first", ev(4'h0, 0, 0, 4'h0), M_MAIN);
    for (int k = 0; k <= 40; k++) begin
      if (k < 10)      begin ph = k;             pw = (ph < 5) ? 4'hF : 4'h0; end
      else if (k < 25) begin ph = (k - 10) % 5;  pw = (ph < 2) ? 4'hF : 4'h0; end
      else if (k < 32) begin ph = k - 25;        pw = (ph < 3) ? 4'hF : 4'h0; end
      else             begin ph = (k - 32) % 3;  pw = (ph < 2) ? 4'hF : 4'h0; end
      up = (k >= 3 && k <= 8) || (k >= 27 && k <= 30);
      cyc("t3_reload", ev(pw, ph == 0, up, 4'h0), M_MAIN);
      case (k)
        2:  begin set_cfg(4, 2, 2, 2, 2, 1'b0, 0); cfg_load = 1'b1; end
        23: begin set_cfg(6, 3, 3, 3, 3, 1'b0, 0); cfg_load = 1'b1; end
        26: begin set_cfg(3, 1, 1, 1, 1, 1'b0, 0); cfg_load = 1'b1; end
        28: begin set_cfg(2, 2, 2, 2, 2, 1'b0, 0); cfg_load = 1'b1; end
        3, 24, 27, 29: cfg_load = 1'b0;
        default: ;
      endcase
    end

    // Enable dropped with pending shadow, then re-enable
    for (int k = 41; k <= 44; k++) begin
      ph = (k - 32) % 3;
      cyc("t5_run", ev((ph < 2) ? 4'hF : 4'h0, ph == 0, k == 44, 4'h0), M_MAIN);
      if (k == 43) begin set_cfg(5, 4, 4, 4, 4, 1'b0, 0); cfg_load = 1'b1; end
      if (k == 44) begin cfg_load = 1'b0; enable = 1'b0; end
    end
    cyc("t5_off", ev(4'h0, 0, 0, 4'h0), M_MAIN);
    cyc("t5_off2", ev(4'h0, 0, 0, 4'h0), M_MAIN);
    enable = 1'b1;
    cyc("t5_reen", ev(4'h0, 0, 0, 4'h0), M_MAIN);
    for (int m = 0; m <= 12; m++) begin
      ph = m % 6;
      cyc("t5_newcfg", ev((ph < 4) ? 4'hF : 4'h0, ph == 0, m == 12, 4'h0), M_MAIN);
      if (m == 11) begin set_cfg(7, 1, 1, 1, 1, 1'b0, 0); cfg_load = 1'b1; end
      if (m == 12) begin cfg_load = 1'b0; reset = 1'b1; end
    end

    // Reset mid-pulse, then P=0 boundary
    cyc("t6_reset", ev(4'h0, 0, 0, 4'h0), M_MAIN);
    cyc("t6_reset_hold", ev(4'h0, 0, 0, 4'h0), M_MAIN);
    reset = 1'b0;
    cyc("t7_r1", ev(4'h0, 0, 0, 4'h0), M_MAIN);
    cyc("t7_p0", ev(4'h0, 1, 0, 4'h0), M_MAIN);
    set_cfg(0, 0, 1, 0, 255, 1'b0, 0); cfg_load = 1'b1;
    cyc("t7_bypass", ev(4'h0, 1, 0, 4'h0), M_MAIN);
    cfg_load = 1'b0;
    for (int k = 0; k < 4; k++) cyc("t7_p0_new", ev(4'b1010, 1, 0, 4'h0), M_MAIN);

`ifdef PWM_DEADTIME_EN
    // Dead time 2 on P=19 duty 10, then dead time 12 suppresses both outputs
    enable = 1'b0; set_cfg(19, 10, 10, 10, 10, 1'b0, 2); cfg_load = 1'b1;
    cyc("dt_dis", ev(4'h0, 0, 0, 4'h0), M_DT);
    cfg_load = 1'b0; enable = 1'b1;
    cyc("dt_first", ev(4'h0, 0, 0, 4'h0), M_DT);
    for (int k = 0; k < 40; k++) begin
      ph = k % 20;
      cyc("dt2", ev((ph >= 2 && ph < 10) ? 4'hF : 4'h0, ph == 0, 0, (ph >= 12) ? 4'hF : 4'h0), M_DT);
    end
    enable = 1'b0; set_cfg(19, 10, 10, 10, 10, 1'b0, 12); cfg_load = 1'b1;
    cyc("dt12_dis", ev(4'h0, 0, 0, 4'h0), M_DT);
    cfg_load = 1'b0; enable = 1'b1;
    cyc("dt12_first", ev(4'h0, 0, 0, 4'h0), M_DT);
    for (int k = 0; k < 40; k++) begin
      ph = k % 20;
      cyc("dt12", ev(4'h0, ph == 0, 0, 4'h0), M_DT);
    end
`endif

    for (int w = 0; w < 20 && sb_q.size() > 0; w++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
